mem_port_arbiter: RTL

//  Shares the single 4Kx8 big-endian byte memory between instruction fetch (I) and data access (D).

---
 rtl/mem_port_arbiter_pkg.sv | 36 +++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter_rr_arb2.sv | 30 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : State encodings, requester IDs and width defaults shared by
//               the arbiter, its interface and the pick sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int ADDR_W_DFLT = 12;
  localparam int DATA_W_DFLT = 32;

  // Keeps the low AW bits of a byte address and zeroes the rest.
  function automatic logic [31:0] mask_addr(input logic [31:0] a, input int aw);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 32; k++) begin
      if (k < aw) m[k] = 1'b1;
    end
    return a & m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and memory-side bus bundle of the port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int DATA_W = mem_port_arbiter_pkg::DATA_W_DFLT
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              m_cs;
  logic              m_wr;
  logic              m_rd;
  logic [31:0]       m_addr;
  logic [DATA_W-1:0] m_din;
  logic [DATA_W-1:0] m_dout;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_dout,
    output i_ack, i_rdata, d_ack, d_rdata, m_cs, m_wr, m_rd, m_addr, m_din
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_dout,
    input  i_ack, i_rdata, d_ack, d_rdata, m_cs, m_wr, m_rd, m_addr, m_din
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way pick between fetch and data requests,
//               fixed priority (D first) or round-robin against the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  wire logic i_req_i,
  input  wire logic i_req_d,
  input  wire logic i_last,
  input  wire logic i_mode,
  output logic      o_gnt
);

  always_comb begin
    o_gnt = PORT_D;
    if (i_req_i && !i_req_d) begin
      o_gnt = PORT_I;
    end else if (i_req_i && i_req_d && i_mode) begin
      o_gnt = ~i_last;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one byte memory between fetch and data requesters, one
//               three-cycle word access at a time. Optional MISALIGN_TRAP_EN
//               adds an err output and suppresses misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DFLT,
  parameter int DATA_W   = DATA_W_DFLT,
  parameter int ARB_MODE = 0
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              err
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rr_last;
  logic [31:0]       r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic              r_cs, r_rd, r_wr;
  logic              r_i_ack, r_d_ack;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;

  logic              w_gnt, w_any, w_sel_wr, w_sel_trap, w_load, w_rr_upd;
  logic              w_cs_nxt, w_rd_nxt, w_wr_nxt, w_i_ack_nxt, w_d_ack_nxt;
  logic [31:0]       w_sel_addr;

  rr_arb2 u_arb (
    .i_req_i (bus.i_req),
    .i_req_d (bus.d_req),
    .i_last  (r_rr_last),
    .i_mode  (ARB_MODE != 0),
    .o_gnt   (w_gnt)
  );

  assign w_any      = bus.i_req | bus.d_req;
  assign w_sel_addr = (w_gnt == PORT_D) ? bus.d_addr : bus.i_addr;
  assign w_sel_wr   = (w_gnt == PORT_D) & bus.d_wr;

`ifdef MISALIGN_TRAP_EN
  logic r_cmd_trap;
  logic r_err;
  assign w_sel_trap = (w_sel_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_trap <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_load) r_cmd_trap <= w_sel_trap;
      r_err <= (r_state == ACC_I || r_state == ACC_D) && r_cmd_trap;
    end
  end

  assign err = r_err;
`else
  assign w_sel_trap = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cs_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_i_ack_nxt = 1'b0;
    w_d_ack_nxt = 1'b0;
    w_rr_upd    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = (w_gnt == PORT_D) ? ACC_D : ACC_I;
          // Strobes are registered, so they are decided here for the ACC cycle.
          w_cs_nxt    = !w_sel_trap;
          w_rd_nxt    = !w_sel_trap && !w_sel_wr;
          w_wr_nxt    = !w_sel_trap && w_sel_wr;
        end
      end
      ACC_I, ACC_D: begin
        w_state_nxt = RESP;
        w_i_ack_nxt = (r_state == ACC_I);
        w_d_ack_nxt = (r_state == ACC_D);
        w_rr_upd    = 1'b1;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_last   <= PORT_I;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cs        <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cs    <= w_cs_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_i_ack <= w_i_ack_nxt;
      r_d_ack <= w_d_ack_nxt;
      if (w_load) begin
        r_cmd_addr  <= mask_addr(w_sel_addr, ADDR_W);
        r_cmd_wdata <= (w_gnt == PORT_D) ? bus.d_wdata : '0;
      end
      if (w_rr_upd) r_rr_last <= (r_state == ACC_D) ? PORT_D : PORT_I;
      if (r_rd && r_state == ACC_I) r_i_rdata <= bus.m_dout;
      if (r_rd && r_state == ACC_D) r_d_rdata <= bus.m_dout;
    end
  end

  assign bus.m_cs    = r_cs;
  assign bus.m_rd    = r_rd;
  assign bus.m_wr    = r_wr;
  assign bus.m_addr  = r_cmd_addr;
  assign bus.m_din   = r_cmd_wdata;
  assign bus.i_ack   = r_i_ack;
  assign bus.d_ack   = r_d_ack;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
  assign busy        = (r_state != IDLE);

endmodule

`default_nettype wire
